// File: rtl/counter_ctrl_pkg.sv
// Shared types and constants for the counter_ctrl button front-end.
// Imported by btn_debounce and counter_ctrl.
package counter_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FIRST,
        HOLD,
        REPEAT
    } count_state_e;

    // Level of an active-low button that is not being pressed.
    localparam logic RELEASED = 1'b1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/counter_ctrl_if.sv
// Button inputs and counter strobes exchanged between the board pins and counter_ctrl.
// slave is the counter_ctrl side; master is the pin/stimulus side.
interface counter_ctrl_if;
    logic clear_btn_n_i;
    logic count_btn_n_i;
    logic clear_o;
    logic count_o;
    logic repeat_o;

    modport slave (
        input  clear_btn_n_i,
        input  count_btn_n_i,
        output clear_o,
        output count_o,
        output repeat_o
    );

    modport master (
        output clear_btn_n_i,
        output count_btn_n_i,
        input  clear_o,
        input  count_o,
        input  repeat_o
    );
endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus counting debouncer for one raw active-low button.
// Outputs the accepted level and a one-cycle strobe on each accepted press.
module btn_debounce
    import counter_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic level,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          sample;
    logic          level_q;
    logic [CW-1:0] cnt;

    // sample retimes the synchronised level so the compare never sits on the metastability flop.
    // NOTE: every flop here uses <= so all stages update together on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= RELEASED;
            sync2   <= RELEASED;
            sample  <= RELEASED;
            level   <= RELEASED;
            level_q <= RELEASED;
            cnt     <= '0;
        end else begin
            sync1   <= btn_n;
            sync2   <= sync1;
            sample  <= sync2;
            level_q <= level;
            if (sample == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sample;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign press = level_q & ~level;

endmodule

// File: rtl/counter_ctrl.sv
// Clear-priority sequencer driving counter.clear / counter.count from two debounced buttons.
// Define COUNTER_CTRL_AUTOREPEAT_EN to build the auto-repeat REPEAT state and repeat_o.
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_PERIOD   = 16
) (
    input logic           clock_i,
    input logic           reset_n_i,
    counter_ctrl_if.slave bus
);

    logic clear_level;
    logic clear_press;
    logic count_level;
    logic count_press;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
        .clk   (clock_i),
        .rst_n (reset_n_i),
        .btn_n (bus.clear_btn_n_i),
        .level (clear_level),
        .press (clear_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_count_db (
        .clk   (clock_i),
        .rst_n (reset_n_i),
        .btn_n (bus.count_btn_n_i),
        .level (count_level),
        .press (count_press)
    );

    count_state_e state;
    count_state_e state_next;
    logic         pulse_next;

`ifdef COUNTER_CTRL_AUTOREPEAT_EN
    localparam int TW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD));
    localparam logic [TW-1:0] DELAY_LOAD  = TW'(REPEAT_DELAY - 2);
    localparam logic [TW-1:0] PERIOD_LOAD = TW'(REPEAT_PERIOD - 1);

    logic [TW-1:0] timer;
    logic [TW-1:0] timer_next;
`endif

    // NOTE: defaults first so no path through this block leaves a signal unassigned (no latches).
    always_comb begin
        state_next = state;
        pulse_next = 1'b0;
`ifdef COUNTER_CTRL_AUTOREPEAT_EN
        timer_next = timer;
`endif
        // A pressed clear owns the counter; the count button must be pressed afresh afterwards.
        if (clear_level != RELEASED || count_level == RELEASED) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (count_press) begin
                        state_next = FIRST;
                        pulse_next = 1'b1;
                    end
                end
                FIRST: begin
                    state_next = HOLD;
`ifdef COUNTER_CTRL_AUTOREPEAT_EN
                    timer_next = DELAY_LOAD;
`endif
                end
                HOLD: begin
`ifdef COUNTER_CTRL_AUTOREPEAT_EN
                    if (timer == '0) begin
                        state_next = REPEAT;
                        pulse_next = 1'b1;
                        timer_next = PERIOD_LOAD;
                    end else begin
                        timer_next = timer - 1'b1;
                    end
`endif
                end
                REPEAT: begin
`ifdef COUNTER_CTRL_AUTOREPEAT_EN
                    if (timer == '0) begin
                        pulse_next = 1'b1;
                        timer_next = PERIOD_LOAD;
                    end else begin
                        timer_next = timer - 1'b1;
                    end
`else
                    state_next = IDLE;
`endif
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state       <= IDLE;
            bus.clear_o <= 1'b0;
            bus.count_o <= 1'b0;
        end else begin
            state       <= state_next;
            bus.clear_o <= clear_press;
            bus.count_o <= pulse_next;
        end
    end

`ifdef COUNTER_CTRL_AUTOREPEAT_EN
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            timer        <= '0;
            bus.repeat_o <= 1'b0;
        end else begin
            timer        <= timer_next;
            bus.repeat_o <= (state_next == REPEAT);
        end
    end
`else
    assign bus.repeat_o = 1'b0;
`endif

endmodule

// File: doc/counter_ctrl.md
# counter_ctrl

Button front-end and sequencer for the 8-bit `counter` datapath on the Brevia2 board. It takes the two raw, bouncing, active-low push-buttons, synchronises and debounces them, and drives the counter's `clear` and `count` inputs. `clear` is issued as a single-cycle pulse. `count` is issued as a single-cycle increment pulse, with optional auto-repeat while the button is held. The block sits between the top-level pins and the `counter` instance, replacing the direct inverters.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronised samples needed to accept a new button level (≥2).
- `REPEAT_DELAY`, default 64: cycles from the first count pulse to the first auto-repeat pulse (≥2).
- `REPEAT_PERIOD`, default 16: cycles between auto-repeat pulses (≥2).

Ports:
- `clock_i` input 1: single clock; all logic on the rising edge.
- `reset_n_i` input 1: reset, asynchronous, active-low.
- `clear_btn_n_i` input 1: raw clear button, active-low, asynchronous to the clock.
- `count_btn_n_i` input 1: raw count button, active-low, asynchronous to the clock.
- `clear_o` output 1: one-cycle clear pulse to `counter.clear`.
- `count_o` output 1: one-cycle increment pulse to `counter.count`.
- `repeat_o` output 1: high while the count FSM is in REPEAT (status/LED).

## Operation
- Each button goes through a 2-flop synchroniser and then a debouncer.
- Debouncer:
  - Holds an accepted level that resets to released (1).
  - A counter increments each cycle the synchronised level differs from the accepted level. It clears to 0 whenever the two are equal.
  - When the counter reaches `DEBOUNCE_CYCLES-1` and the levels still differ, the accepted level flips and the counter clears.
- A press event is a falling edge of the accepted level (a registered previous value is kept for edge detection).
- Clear path: a press event on clear gives `clear_o`=1 for exactly one cycle. Holding clear gives no further pulses.
- Count FSM states are IDLE, FIRST, HOLD and REPEAT. A cycle counter sized `$clog2(max(REPEAT_DELAY,REPEAT_PERIOD))` bits is used for HOLD and REPEAT timing.
  - IDLE → FIRST on a count press event while clear is not accepted-pressed.
  - FIRST: `count_o`=1 for one cycle, load the counter, → HOLD.
  - HOLD: after `REPEAT_DELAY-1` further cycles → REPEAT with `count_o`=1.
  - REPEAT: `count_o`=1 every `REPEAT_PERIOD` cycles.
  - Any state → IDLE when count is accepted-released.
- Clear priority:
  - While clear is accepted-pressed, the count FSM is forced to IDLE and `count_o` is forced to 0.
  - Count pulses resume only on a fresh count press event after clear is released. A count button held across a clear produces nothing.
- Simultaneous press events in the same cycle: `clear_o`=1 and `count_o`=0.
- `clear_o` and `count_o` are never high in the same cycle.
- Reset values: `clear_o`=0, `count_o`=0, `repeat_o`=0, synchroniser flops 1, accepted levels released, FSM IDLE, all counters 0.
- Reset asserted mid-operation: all state returns to reset values immediately, with no pulse emitted. If a button is held low through reset release, it is treated as a new press and produces a pulse after the normal latency.

## Timing
- Press latency: the raw input is first sampled low at edge 0. The accepted level flips at edge `DEBOUNCE_CYCLES+2`. `clear_o`/`count_o` are registered high after edge `DEBOUNCE_CYCLES+3`, for one cycle.
- Glitches shorter than `DEBOUNCE_CYCLES` synchronised cycles are rejected.
- Auto-repeat: with the first pulse at cycle t0, pulses occur at t0+`REPEAT_DELAY`, then t0+`REPEAT_DELAY`+k·`REPEAT_PERIOD`.
- Release latency: FSM returns to IDLE `DEBOUNCE_CYCLES+3` cycles after the raw release. No pulse is emitted on release.
- All outputs are registered with no combinational path from inputs.

## Configuration
- `COUNTER_CTRL_AUTOREPEAT_EN` defined: the full FSM with REPEAT as described.
- Undefined:
  - HOLD waits for release only and REPEAT is not synthesised.
  - `repeat_o` is tied 0 and `REPEAT_DELAY`/`REPEAT_PERIOD` are ignored.
  - Exactly one `count_o` pulse per press.

## Structure
- Package `counter_ctrl_pkg`: FSM state typedef (IDLE, FIRST, HOLD, REPEAT) and the released-level constant (1'b1).
- Sub-module `btn_debounce`, instantiated twice: synchroniser plus debouncer. Parameter `DEBOUNCE_CYCLES`, outputs accepted level and press-event strobe.
- `counter_ctrl` holds the clear-priority logic, the count FSM and the output registers.

## Test plan
Benches use `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=8, `REPEAT_PERIOD`=3.
- Bounce rejection: `count_btn_n_i` low for 3 cycles then high → `count_o` never asserts.
- Clean count press held 6 cycles, macro undefined → exactly one `count_o` pulse at edge 7; `counter` Q goes 0→1.
- Auto-repeat with macro defined, held 30 cycles → `count_o` pulses at edges 7, 15, 18, 21, 24, …; `repeat_o`=1 from edge 15 until release.
- Simultaneous clear and count presses at the same edge → `clear_o` pulse at edge 7, no `count_o`. Clear released with count still held → no count pulse.
- Reset pulse asserted during REPEAT with count held → outputs 0 at once. After release, first `count_o` at edge 7 relative to reset deassertion.
- Clear press while Q=0x25 → one `clear_o` pulse; Q=0x00 the next cycle; holding clear for 40 cycles gives no further pulses.
